// File: rtl/dsp_mult_add_slice_if.sv
// Operand and result bundle for the multiply-add slice.
// With DSP_OVF_EN defined the bundle also carries the overflow flag.
interface dsp_mult_add_slice_if;
    logic [24:0] a;
    logic [17:0] b;
    logic [47:0] c;
    logic [47:0] pcin;
    logic        carryin;
    logic [6:0]  opmode;
    logic        alumode;
    logic [47:0] p;
`ifdef DSP_OVF_EN
    logic        ovf;
`endif

    modport master (
        output a, b, c, pcin, carryin, opmode, alumode,
`ifdef DSP_OVF_EN
        input  ovf,
`endif
        input  p
    );

    modport slave (
        input  a, b, c, pcin, carryin, opmode, alumode,
`ifdef DSP_OVF_EN
        output ovf,
`endif
        output p
    );
endinterface

// File: rtl/dsp_mult_add_slice.sv
// Signed multiply-add slice: P = Z +/- (X + Y + CARRYIN), optional A/B/C/M/P regs.
// Optional overflow flag output enabled by defining DSP_OVF_EN.
module dsp_mult_add_slice #(
    parameter int AREG = 0,
    parameter int BREG = 0,
    parameter int CREG = 0,
    parameter int MREG = 0,
    parameter int PREG = 1
) (
    input logic clk,
    input logic rst,
    input logic ce,
    dsp_mult_add_slice_if.slave bus
);

`ifdef DSP_OVF_EN
    localparam int SW = 50;
`else
    localparam int SW = 48;
`endif

    logic signed [24:0] a_d, a_q;
    logic signed [17:0] b_d, b_q;
    logic signed [47:0] c_d, c_q;
    logic signed [42:0] m_d, m_q;
    logic        [47:0] p_d, p_q;
    logic        [47:0] pfb;

    assign a_d = bus.a;
    assign b_d = bus.b;
    assign c_d = bus.c;
    assign m_d = a_q * b_q;

    if (AREG != 0) begin : g_areg
        always_ff @(posedge clk)
            if (rst)     a_q <= '0;
            else if (ce) a_q <= a_d;
    end else begin : g_awire
        assign a_q = a_d;
    end

    if (BREG != 0) begin : g_breg
        always_ff @(posedge clk)
            if (rst)     b_q <= '0;
            else if (ce) b_q <= b_d;
    end else begin : g_bwire
        assign b_q = b_d;
    end

    if (CREG != 0) begin : g_creg
        always_ff @(posedge clk)
            if (rst)     c_q <= '0;
            else if (ce) c_q <= c_d;
    end else begin : g_cwire
        assign c_q = c_d;
    end

    if (MREG != 0) begin : g_mreg
        always_ff @(posedge clk)
            if (rst)     m_q <= '0;
            else if (ce) m_q <= m_d;
    end else begin : g_mwire
        assign m_q = m_d;
    end

    logic signed [47:0] x_s, y_s, z_s;

    always_comb begin
        x_s = '0;
        unique case (bus.opmode[1:0])
            2'b00: x_s = '0;
            2'b01: x_s = {{5{m_q[42]}}, m_q};
            2'b10: x_s = pfb;
            2'b11: x_s = {{5{a_q[24]}}, a_q, b_q};
            default: x_s = '0;
        endcase
    end

    assign y_s = (bus.opmode[3:2] == 2'b11) ? c_q : '0;

    always_comb begin
        z_s = '0;
        unique case (bus.opmode[6:4])
            3'b001:  z_s = bus.pcin;
            3'b010:  z_s = pfb;
            3'b011:  z_s = c_q;
            default: z_s = '0;
        endcase
    end

    // Operands widened by two bits when the overflow flag is needed.
    logic signed [SW-1:0] xw, yw, zw, cw, sum_w;

    assign xw    = x_s;
    assign yw    = y_s;
    assign zw    = z_s;
    assign cw    = {{(SW-1){1'b0}}, bus.carryin};
    assign sum_w = bus.alumode ? zw - (xw + yw + cw) : zw + xw + yw + cw;
    assign p_d   = sum_w[47:0];

`ifdef DSP_OVF_EN
    logic ovf_d, ovf_q;
    assign ovf_d = (sum_w[49:47] != 3'b000) && (sum_w[49:47] != 3'b111);
`endif

    if (PREG != 0) begin : g_preg
        always_ff @(posedge clk)
            if (rst)     p_q <= '0;
            else if (ce) p_q <= p_d;
        assign pfb = p_q;
`ifdef DSP_OVF_EN
        always_ff @(posedge clk)
            if (rst)     ovf_q <= 1'b0;
            else if (ce) ovf_q <= ovf_d;
`endif
    end else begin : g_pwire
        assign p_q = p_d;
        assign pfb = '0;
`ifdef DSP_OVF_EN
        assign ovf_q = ovf_d;
`endif
    end

    assign bus.p = p_q;
`ifdef DSP_OVF_EN
    assign bus.ovf = ovf_q;
`endif

endmodule

// File: tb/tb_dsp_mult_add_slice.sv
// Directed bench: combinational vector table plus pipelined and accumulator sequences.
module tb_dsp_mult_add_slice;
    logic clk = 1'b0;
    logic rst;
    logic ce;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    dsp_mult_add_slice_if if0 ();
    dsp_mult_add_slice_if if1 ();
    dsp_mult_add_slice_if if2 ();

    dsp_mult_add_slice #(.AREG(0), .BREG(0), .CREG(0), .MREG(0), .PREG(0))
        u0 (.clk(clk), .rst(rst), .ce(ce), .bus(if0));
    dsp_mult_add_slice #(.AREG(1), .BREG(1), .CREG(1), .MREG(1), .PREG(1))
        u1 (.clk(clk), .rst(rst), .ce(ce), .bus(if1));
    dsp_mult_add_slice #(.AREG(0), .BREG(0), .CREG(0), .MREG(0), .PREG(1))
        u2 (.clk(clk), .rst(rst), .ce(ce), .bus(if2));

    typedef struct {
        logic [6:0]  op;
        logic        alu;
        logic        ci;
        logic [24:0] a;
        logic [17:0] b;
        logic [47:0] c;
        logic [47:0] pcin;
        logic [47:0] p;
        logic        ovf;
    } vec_t;

    vec_t vt[13];

    task automatic chk(input string nm, input logic [47:0] act, input logic [47:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vt[0]  = '{7'b011_00_01, 1'b0, 1'b0, 25'sd3, -18'sd131072, 48'sd5, 48'd0,
                   -48'sd393211, 1'b0};
        vt[1]  = '{7'b011_00_01, 1'b1, 1'b1, 25'sd4, 18'sd3, 48'sd10, 48'd0,
                   -48'sd3, 1'b0};
        vt[2]  = '{7'b011_00_00, 1'b0, 1'b1, 25'd0, 18'd0, 48'h7FFF_FFFF_FFFF, 48'd0,
                   48'h8000_0000_0000, 1'b1};
        vt[3]  = '{7'b000_00_11, 1'b0, 1'b0, 25'sd1, 18'sd2, 48'd0, 48'd0,
                   48'h0000_0004_0002, 1'b0};
        vt[4]  = '{7'b000_11_00, 1'b0, 1'b0, 25'd0, 18'd0, -48'sd7, 48'd0,
                   -48'sd7, 1'b0};
        vt[5]  = '{7'b001_00_01, 1'b0, 1'b0, -25'sd5, 18'sd6, 48'd0, 48'd1000,
                   48'd970, 1'b0};
        vt[6]  = '{7'b100_11_01, 1'b0, 1'b0, 25'sd2, 18'sd3, 48'd4, 48'd0,
                   48'd10, 1'b0};
        vt[7]  = '{7'b000_10_01, 1'b0, 1'b0, 25'sd2, 18'sd3, 48'd4, 48'd0,
                   48'd6, 1'b0};
        vt[8]  = '{7'b001_00_10, 1'b0, 1'b0, 25'sd9, 18'sd9, 48'd0, 48'd77,
                   48'd77, 1'b0};
        vt[9]  = '{7'b010_00_01, 1'b0, 1'b0, 25'sd2, 18'sd3, 48'd0, 48'd0,
                   48'd6, 1'b0};
        vt[10] = '{7'b011_00_01, 1'b1, 1'b0, 25'sd1, 18'sd1, 48'h8000_0000_0000, 48'd0,
                   48'h7FFF_FFFF_FFFF, 1'b1};
        vt[11] = '{7'b000_00_01, 1'b0, 1'b0, 25'h100_0000, 18'h2_0000, 48'd0, 48'd0,
                   48'h0200_0000_0000, 1'b0};
        vt[12] = '{7'b011_11_00, 1'b0, 1'b0, 25'd0, 18'd0, 48'h7FFF_FFFF_FFFF, 48'd0,
                   48'hFFFF_FFFF_FFFE, 1'b1};

        rst = 1'b1;
        ce  = 1'b1;
        if0.a = '0; if0.b = '0; if0.c = '0; if0.pcin = '0;
        if0.carryin = 1'b0; if0.opmode = '0; if0.alumode = 1'b0;
        if1.a = '0; if1.b = '0; if1.c = '0; if1.pcin = '0;
        if1.carryin = 1'b0; if1.opmode = 7'b011_00_01; if1.alumode = 1'b0;
        if2.a = '0; if2.b = '0; if2.c = '0; if2.pcin = '0;
        if2.carryin = 1'b0; if2.opmode = 7'b010_00_01; if2.alumode = 1'b0;
        tick();
        tick();
        chk("rst_p_pipe", if1.p, 48'd0);
        chk("rst_p_acc", if2.p, 48'd0);
`ifdef DSP_OVF_EN
        chk("rst_ovf", {47'd0, if2.ovf}, 48'd0);
`endif
        rst = 1'b0;

        for (int i = 0; i < 13; i++) begin
            if0.opmode  = vt[i].op;
            if0.alumode = vt[i].alu;
            if0.carryin = vt[i].ci;
            if0.a       = vt[i].a;
            if0.b       = vt[i].b;
            if0.c       = vt[i].c;
            if0.pcin    = vt[i].pcin;
            #1;
            chk($sformatf("vec%0d_p", i), if0.p, vt[i].p);
`ifdef DSP_OVF_EN
            chk($sformatf("vec%0d_ovf", i), {47'd0, if0.ovf}, {47'd0, vt[i].ovf});
`endif
        end

        // Pipelined slice: a/b latency 3, c latency 2
        if1.a = 25'sd2; if1.b = 18'sd7; if1.c = 48'd100;
        tick();
        chk("pipe_e1", if1.p, 48'd0);
        if1.a = '0; if1.b = '0;
        tick();
        chk("pipe_c_e2", if1.p, 48'd100);
        tick();
        chk("pipe_m_e3", if1.p, 48'd114);
        tick();
        chk("pipe_e4", if1.p, 48'd100);

        // Reset flushes an in-flight product
        if1.a = 25'sd2; if1.b = 18'sd7;
        tick();
        if1.a = '0; if1.b = '0; if1.c = '0;
        rst = 1'b1;
        tick();
        chk("flush_rst", if1.p, 48'd0);
        rst = 1'b0;
        tick();
        chk("flush_e1", if1.p, 48'd0);
        tick();
        chk("flush_e2", if1.p, 48'd0);

        // Accumulator: p += a*b each enabled cycle
        if2.a = 25'sd1; if2.b = 18'sd1;
        for (int k = 1; k <= 5; k++) begin
            tick();
            chk($sformatf("acc_%0d", k), if2.p, 48'(k));
        end
        ce = 1'b0;
        tick();
        tick();
        chk("acc_hold", if2.p, 48'd5);
        rst = 1'b1;
        tick();
        chk("acc_rst_noce", if2.p, 48'd0);
        rst = 1'b0;
        ce  = 1'b1;
        tick();
        chk("acc_restart", if2.p, 48'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
